// File: rtl/restoring_divider_pkg.sv
// restoring_divider_pkg: shared FSM state type, default width and counter sizing for the divider
package restoring_divider_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  localparam int DEF_WIDTH = 10;
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/restoring_divider_prefix_sub.sv
// prefix_sub: Sklansky prefix subtractor a-b computed as a+~b+1 with black/grey cells
module prefix_sub #(
  parameter int N = 11
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);
  localparam int L = $clog2(N);
  logic [N-1:0] pi, gi;
  logic [N-1:0] g [0:L];
  logic [N-1:0] p [0:L];
  assign pi = a ^ ~b;
  assign gi = a & ~b;
  // the constant carry-in of 1 is folded into bit 0's generate
  assign g[0] = {gi[N-1:1], gi[0] | pi[0]};
  assign p[0] = pi;
  for (genvar l = 0; l < L; l++) begin : g_lvl
    for (genvar i = 0; i < N; i++) begin : g_bit
      if (((i >> l) & 1) == 1) begin : g_cell
        localparam int J = ((i >> l) << l) - 1;
        if (i < (2 << l)) begin : g_grey
          assign g[l+1][i] = g[l][i] | (p[l][i] & g[l][J]);
          assign p[l+1][i] = p[l][i];
        end else begin : g_black
          assign g[l+1][i] = g[l][i] | (p[l][i] & g[l][J]);
          assign p[l+1][i] = p[l][i] & p[l][J];
        end
      end else begin : g_pass
        assign g[l+1][i] = g[l][i];
        assign p[l+1][i] = p[l][i];
      end
    end
  end
  assign diff   = pi ^ {g[L][N-2:0], 1'b1};
  assign borrow = ~g[L][N-1];
endmodule

// File: rtl/restoring_divider.sv
// restoring_divider: one-bit-per-cycle unsigned restoring divider with valid/ready handshakes
module restoring_divider
  import restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = cnt_w(WIDTH);
  state_e state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d, r_q, r_d, d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic dbz_q, dbz_d;
  logic [WIDTH:0] s, diff;
  logic borrow;
  assign s = {r_q, q_q[WIDTH-1]};
  prefix_sub #(.N(WIDTH+1)) u_sub (
    .a     (s),
    .b     ({1'b0, d_q}),
    .diff  (diff),
    .borrow(borrow)
  );
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: if (in_valid) begin
        dbz_d   = divisor == '0;
        d_d     = divisor;
        cnt_d   = '0;
        q_d     = dbz_d ? '1 : dividend;
        r_d     = dbz_d ? dividend : '0;
        state_d = dbz_d ? DONE : CALC;
      end
      CALC: begin
        r_d     = borrow ? s[WIDTH-1:0] : diff[WIDTH-1:0];
        q_d     = {q_q[WIDTH-2:0], ~borrow};
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == CW'(WIDTH-1) ? DONE : CALC;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end
  assign in_ready    = state_q == IDLE;
  assign out_valid   = state_q == DONE;
  assign quotient    = q_q;
  assign remainder   = r_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider: directed vectors with a queue scoreboard checked by an output monitor
module tb_restoring_divider;
  localparam int W = 10;
  typedef struct {
    int q;
    int r;
    int z;
  } exp_t;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, div_by_zero;
  logic [W-1:0] dividend, divisor, quotient, remainder;
  exp_t sb[$];
  int n_vec = 0;
  int n_err = 0;
  restoring_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_op(input int a, input int b, input int eq, input int er, input int ez, input int elat);
    int k;
    exp_t e;
    k = 0;
    while (!in_ready && k < 40) begin
      tick();
      k++;
    end
    chk("in_ready_before_op", int'(in_ready), 1);
    in_valid = 1'b1;
    dividend = W'(a);
    divisor  = W'(b);
    e.q = eq;
    e.r = er;
    e.z = ez;
    sb.push_back(e);
    tick();
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 40) begin
      tick();
      k++;
    end
    chk($sformatf("latency %0d/%0d", a, b), k, elat);
  endtask
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst && in_ready && out_valid) begin
        n_err++;
        $display("FAIL ready_valid_overlap: in_ready=1 out_valid=1 required not both");
      end
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("quotient", int'(quotient), e.q);
          chk("remainder", int'(remainder), e.r);
          chk("div_by_zero", int'(div_by_zero), e.z);
        end
      end
    end
  end
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end
  initial begin : stim
    int seen;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    dividend = '0;
    divisor = '0;
    tick();
    tick();
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_quotient", int'(quotient), 0);
    chk("rst_remainder", int'(remainder), 0);
    chk("rst_dbz", int'(div_by_zero), 0);
    rst = 1'b0;
    tick();
    do_op(1000, 7, 142, 6, 0, 10);
    do_op(1023, 1, 1023, 0, 0, 10);
    do_op(1023, 1023, 1, 0, 0, 10);
    do_op(3, 1023, 0, 3, 0, 10);
    do_op(0, 5, 0, 0, 0, 10);
    do_op(5, 0, 1023, 5, 1, 0);
    tick();
    // hold the result under back-pressure while the inputs churn
    out_ready = 1'b0;
    do_op(1000, 7, 142, 6, 0, 10);
    for (int i = 0; i < 6; i++) begin
      in_valid = i[0];
      dividend = W'(37 * i + 11);
      divisor  = W'(i);
      tick();
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_quotient", int'(quotient), 142);
      chk("bp_remainder", int'(remainder), 6);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("release_in_ready", int'(in_ready), 1);
    chk("release_out_valid", int'(out_valid), 0);
    do_op(100, 10, 10, 0, 0, 10);
    tick();
    // abandon an operation with reset during its fourth iteration
    in_valid = 1'b1;
    dividend = W'(1000);
    divisor  = W'(7);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_quotient", int'(quotient), 0);
    chk("midrst_remainder", int'(remainder), 0);
    chk("midrst_dbz", int'(div_by_zero), 0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid) seen = 1;
    end
    chk("midrst_no_result", seen, 0);
    do_op(64, 8, 8, 0, 0, 10);
    tick();
    tick();
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
